inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache.sv | 152 +++++++++++++++
 tb/tb_inst_cache.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache
//   Direct-mapped, one-word-per-line instruction cache placed between the core
//   fetch stage and a slow backing memory. A hit returns the instruction in the
//   same cycle. A miss stalls the front end and sends one refill request to
//   memory. When the acknowledge arrives, the cache installs the line and looks
//   the fetch address up again, so the word then reaches the core as a hit.
//
// Ports
//   clock                 : single rising-edge clock
//   reset                 : synchronous, active-high
//   chip_enable_input     : fetch request from pc_reg
//   address_input[31:0]   : fetch byte address (bits [1:0] ignored)
//   flush_input           : invalidate every line
//   data_output[31:0]     : instruction word (32'h0 / NOP when not a hit)
//   stop_all_req_from_if  : stall request to ctrl (freezes PC and IF/ID)
//   mem_req_output        : registered refill request to backing memory
//   mem_address_output    : registered word-aligned refill address
//   mem_data_input[31:0]  : refill data, valid while mem_ack_input is high
//   mem_ack_input         : one-cycle refill completion strobe
// -----------------------------------------------------------------------------
module inst_cache #(
    parameter int INDEX_WIDTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chip_enable_input,
    input  logic [31:0] address_input,
    input  logic        flush_input,
    output logic [31:0] data_output,
    output logic        stop_all_req_from_if,
    output logic        mem_req_output,
    output logic [31:0] mem_address_output,
    input  logic [31:0] mem_data_input,
    input  logic        mem_ack_input
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;

    logic [TAG_WIDTH-1:0]   tag_ram_q  [LINES];
    logic [31:0]            data_ram_q [LINES];

    logic [INDEX_WIDTH-1:0] lookup_index;
    logic [TAG_WIDTH-1:0]   lookup_tag;
    logic                   hit;

    logic                   fill_en;
    logic [INDEX_WIDTH-1:0] fill_index;
    logic [TAG_WIDTH-1:0]   fill_tag;

    // Lookup of the current fetch address against the stored lines.
    always_comb begin
        lookup_index = address_input[INDEX_WIDTH+1:2];
        lookup_tag   = address_input[31:INDEX_WIDTH+2];
        hit          = chip_enable_input & valid_q[lookup_index]
                       & (tag_ram_q[lookup_index] == lookup_tag);
        fill_index   = mem_addr_q[INDEX_WIDTH+1:2];
        fill_tag     = mem_addr_q[31:INDEX_WIDTH+2];
    end

    // Core-facing outputs are combinational so that a hit costs no cycles.
    always_comb begin
        data_output          = 32'h0;
        stop_all_req_from_if = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        data_output = data_ram_q[lookup_index];
                    end else if (chip_enable_input) begin
                        stop_all_req_from_if = 1'b1;
                    end
                end
                REFILL: stop_all_req_from_if = 1'b1;
                default: stop_all_req_from_if = 1'b0;
            endcase
        end
    end

    // Next-state logic. When a flush lands on the ack edge, the flush wins:
    // the refill completes as far as the FSM is concerned, but the line is
    // not installed.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fill_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (chip_enable_input && !hit) begin
                    state_d    = REFILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = address_input & ~32'h3;
                end
            end
            REFILL: begin
                if (mem_ack_input) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    fill_en   = !flush_input;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = valid_q;
        if (flush_input) begin
            valid_d = '0;
        end else if (fill_en) begin
            valid_d[fill_index] = 1'b1;
        end
    end

    // Control state, valid bits and registered memory-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Tag/data storage is never reset. The valid bits alone decide whether
    // a line is usable.
    always_ff @(posedge clock) begin
        if (!reset && fill_en) begin
            tag_ram_q[fill_index]  <= fill_tag;
            data_ram_q[fill_index] <= mem_data_input;
        end
    end

    assign mem_req_output     = mem_req_q;
    assign mem_address_output = mem_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// -----------------------------------------------------------------------------
// tb_inst_cache
//   Self-checking bench for inst_cache (INDEX_WIDTH = 4). The bench acts as the
//   backing memory. It also keeps a simple line table (valid/tag/word per
//   index) that predicts hits and misses.
// -----------------------------------------------------------------------------
module tb_inst_cache;

    logic        clock;
    logic        reset;
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] data_out;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;

    int total;
    int bad;

    // Reference line table: index = (addr / 4) % 16, tag = addr / 64.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_data  [16];

    inst_cache #(.INDEX_WIDTH(4)) dut (
        .clock                (clock),
        .reset                (reset),
        .chip_enable_input    (ce),
        .address_input        (addr),
        .flush_input          (flush),
        .data_output          (data_out),
        .stop_all_req_from_if (stall),
        .mem_req_output       (mem_req),
        .mem_address_output   (mem_addr),
        .mem_data_input       (mem_data),
        .mem_ack_input        (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] a, input logic [31:0] w);
        int unsigned idx;
        idx = (a >> 2) % 16;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a >> 6;
        m_data[idx]  = w;
    endtask

    // Drives one fetch that is expected to miss. The bench plays the memory
    // and acks 'lat' cycles after mem_req rises. It raises flush in cycle
    // 'flush_cycle' (-1 = never; cycle 0 is the miss cycle, cycle lat+1 is the
    // ack cycle). After the ack it presents one more cycle with ce = ce_after
    // and reports what it observed.
    task automatic do_miss(input logic [31:0] a, input int lat, input logic [31:0] w,
                           input int flush_cycle, input logic ce_after,
                           output int stall_cycles, output logic [31:0] req_addr,
                           output logic req_held, output logic [31:0] data_after,
                           output logic stall_after, output logic req_after);
        stall_cycles = 0;
        req_held     = 1'b1;
        req_addr     = 32'h0;
        for (int c = 0; c <= lat + 1; c++) begin
            ce       = 1'b1;
            addr     = a;
            flush    = (c == flush_cycle);
            mem_ack  = (c == lat + 1);
            mem_data = (c == lat + 1) ? w : $urandom();
            @(negedge clock);
            if (stall) stall_cycles++;
            if (c >= 1) begin
                if (mem_req !== 1'b1) req_held = 1'b0;
                if (c == 1) req_addr = mem_addr;
                else if (mem_addr !== req_addr) req_held = 1'b0;
            end
            step();
        end
        flush   = 1'b0;
        mem_ack = 1'b0;
        ce      = ce_after;
        addr    = a;
        @(negedge clock);
        data_after  = data_out;
        stall_after = stall;
        req_after   = mem_req;
        step();
        ce = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; addr = 32'h4; flush = 1'b0;
        mem_ack = 1'b0; mem_data = 32'h0;
        step();
        step();
        @(negedge clock);
        total++; if (data_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want %h", data_out, 32'h0); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want %h", mem_addr, 32'h0); end
        step();
        reset = 1'b0; ce = 1'b0;
        model_flush();
        step();
    endtask

    task automatic test_cold_miss();
        int sc; logic [31:0] ra, da; logic rh, sa, rq;
        do_miss(32'h4, 3, 32'h3401_1100, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h4, 32'h3401_1100);
        total++; if (sc !== 5) begin bad++; $display("[TB] FAIL cold_stall_cycles: got %0d want 5", sc); end
        total++; if (ra !== 32'h4) begin bad++; $display("[TB] FAIL cold_req_addr: got %h want %h", ra, 32'h4); end
        total++; if (rh !== 1'b1) begin bad++; $display("[TB] FAIL cold_req_held: got %b want 1", rh); end
        total++; if (da !== 32'h3401_1100) begin bad++; $display("[TB] FAIL cold_data: got %h want %h", da, 32'h3401_1100); end
        total++; if (sa !== 1'b0) begin bad++; $display("[TB] FAIL cold_stall_after: got %b want 0", sa); end
        total++; if (rq !== 1'b0) begin bad++; $display("[TB] FAIL cold_req_dropped: got %b want 0", rq); end
    endtask

    task automatic test_hit();
        ce = 1'b1; addr = 32'h4;
        @(negedge clock);
        total++; if (data_out !== 32'h3401_1100) begin bad++; $display("[TB] FAIL hit_data: got %h want %h", data_out, 32'h3401_1100); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL hit_stall: got %b want 0", stall); end
        step();
        addr = 32'h7;
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL hit_no_req: got %b want 0", mem_req); end
        total++; if (data_out !== 32'h3401_1100) begin bad++; $display("[TB] FAIL hit_low_bits: got %h want %h", data_out, 32'h3401_1100); end
        step();
        ce = 1'b0;
    endtask

    task automatic test_conflict();
        int sc; logic [31:0] ra, da; logic rh, sa, rq;
        do_miss(32'h44, 2, 32'hAAAA_0044, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h44, 32'hAAAA_0044);
        total++; if (sc !== 4) begin bad++; $display("[TB] FAIL conflict_stall: got %0d want 4", sc); end
        total++; if (ra !== 32'h44) begin bad++; $display("[TB] FAIL conflict_req_addr: got %h want %h", ra, 32'h44); end
        total++; if (da !== 32'hAAAA_0044) begin bad++; $display("[TB] FAIL conflict_data: got %h want %h", da, 32'hAAAA_0044); end
        do_miss(32'h4, 1, 32'h3401_1100, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h4, 32'h3401_1100);
        total++; if (sc !== 3) begin bad++; $display("[TB] FAIL conflict_remiss: got %0d want 3", sc); end
        total++; if (da !== 32'h3401_1100) begin bad++; $display("[TB] FAIL conflict_refill_data: got %h want %h", da, 32'h3401_1100); end
    endtask

    task automatic test_flush();
        int sc; logic [31:0] ra, da; logic rh, sa, rq;
        do_miss(32'h0, 1, 32'h0000_1111, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h0, 32'h0000_1111);
        total++; if (sc !== 3) begin bad++; $display("[TB] FAIL flush_fill0_stall: got %0d want 3", sc); end
        // Lookup in the flush cycle still sees the old valid bits.
        ce = 1'b1; addr = 32'h0; flush = 1'b1;
        @(negedge clock);
        total++; if (data_out !== 32'h0000_1111) begin bad++; $display("[TB] FAIL flush_same_cycle_data: got %h want %h", data_out, 32'h0000_1111); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_same_cycle_stall: got %b want 0", stall); end
        step();
        flush = 1'b0;
        model_flush();
        do_miss(32'h0, 2, 32'h0000_2222, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h0, 32'h0000_2222);
        total++; if (sc !== 4) begin bad++; $display("[TB] FAIL flush_addr0_miss: got %0d want 4", sc); end
        do_miss(32'h4, 0, 32'h0000_4444, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h4, 32'h0000_4444);
        total++; if (sc !== 2) begin bad++; $display("[TB] FAIL flush_addr4_miss: got %0d want 2", sc); end
        total++; if (da !== 32'h0000_4444) begin bad++; $display("[TB] FAIL flush_addr4_data: got %h want %h", da, 32'h0000_4444); end
        // Flush on the ack edge: refill ends, line not installed.
        do_miss(32'h8, 2, 32'h0000_8888, 3, 1'b0, sc, ra, rh, da, sa, rq);
        model_flush();
        total++; if (sc !== 4) begin bad++; $display("[TB] FAIL ackflush_stall: got %0d want 4", sc); end
        total++; if (rq !== 1'b0) begin bad++; $display("[TB] FAIL ackflush_req_dropped: got %b want 0", rq); end
        total++; if (sa !== 1'b0) begin bad++; $display("[TB] FAIL ackflush_idle_stall: got %b want 0", sa); end
        do_miss(32'h8, 1, 32'h0000_8899, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h8, 32'h0000_8899);
        total++; if (sc !== 3) begin bad++; $display("[TB] FAIL ackflush_not_installed: got %0d want 3", sc); end
        total++; if (da !== 32'h0000_8899) begin bad++; $display("[TB] FAIL ackflush_refill_data: got %h want %h", da, 32'h0000_8899); end
        // Flush during refill without ack: line is still installed.
        do_miss(32'hC, 3, 32'h0000_CCCC, 2, 1'b1, sc, ra, rh, da, sa, rq);
        model_flush();
        model_fill(32'hC, 32'h0000_CCCC);
        total++; if (sc !== 5) begin bad++; $display("[TB] FAIL midflush_stall: got %0d want 5", sc); end
        total++; if (da !== 32'h0000_CCCC) begin bad++; $display("[TB] FAIL midflush_installed: got %h want %h", da, 32'h0000_CCCC); end
        total++; if (sa !== 1'b0) begin bad++; $display("[TB] FAIL midflush_stall_after: got %b want 0", sa); end
    endtask

    task automatic test_reset_mid_refill();
        int sc; logic [31:0] ra, da; logic rh, sa, rq;
        ce = 1'b1; addr = 32'h10;
        step();
        @(negedge clock);
        total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_req_rose: got %b want 1", mem_req); end
        step();
        reset = 1'b1;
        @(negedge clock);
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_stall_in_reset: got %b want 0", stall); end
        total++; if (data_out !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_data_in_reset: got %h want %h", data_out, 32'h0); end
        step();
        reset = 1'b0; ce = 1'b0; mem_ack = 1'b1; mem_data = 32'hDEAD_0010;
        model_flush();
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_req_low: got %b want 0", mem_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_stall_low: got %b want 0", stall); end
        step();
        mem_ack = 1'b0;
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_late_ack_ignored: got %b want 0", mem_req); end
        step();
        do_miss(32'h10, 1, 32'h0000_1010, -1, 1'b1, sc, ra, rh, da, sa, rq);
        model_fill(32'h10, 32'h0000_1010);
        total++; if (sc !== 3) begin bad++; $display("[TB] FAIL rstmid_not_installed: got %0d want 3", sc); end
        total++; if (da !== 32'h0000_1010) begin bad++; $display("[TB] FAIL rstmid_refill_data: got %h want %h", da, 32'h0000_1010); end
    endtask

    task automatic test_ce_low();
        for (int i = 0; i < 6; i++) begin
            ce = 1'b0;
            addr = (i % 2 == 0) ? 32'h10 : $urandom();
            @(negedge clock);
            total++; if (data_out !== 32'h0) begin bad++; $display("[TB] FAIL ce_low_data: got %h want %h", data_out, 32'h0); end
            total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL ce_low_stall: got %b want 0", stall); end
            step();
        end
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL ce_low_no_req: got %b want 0", mem_req); end
        step();
    endtask

    task automatic test_random();
        int unsigned op, idx, tg, lat;
        int fc;
        logic [31:0] a, w;
        int sc; logic [31:0] ra, da; logic rh, sa, rq;
        bit exp_hit, ack_flush, do_flush;
        for (int it = 0; it < 80; it++) begin
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            tg  = $urandom_range(0, 2);
            a   = (tg << 6) | (idx << 2) | $urandom_range(0, 3);
            if (op <= 6) begin
                exp_hit = m_valid[idx] && (m_tag[idx] == tg);
                if (exp_hit) begin
                    do_flush = ($urandom_range(0, 3) == 0);
                    ce = 1'b1; addr = a; flush = do_flush;
                    @(negedge clock);
                    total++; if (data_out !== m_data[idx]) begin bad++; $display("[TB] FAIL rand_hit_data: addr %h got %h want %h", a, data_out, m_data[idx]); end
                    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rand_hit_stall: addr %h got %b want 0", a, stall); end
                    step();
                    if (do_flush) model_flush();
                    flush = 1'b0; ce = 1'b0;
                end else begin
                    lat = $urandom_range(0, 4);
                    w   = $urandom();
                    fc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat + 1)) : -1;
                    ack_flush = (fc == int'(lat) + 1);
                    do_miss(a, lat, w, fc, !ack_flush, sc, ra, rh, da, sa, rq);
                    if (fc >= 0) model_flush();
                    if (!ack_flush) model_fill(a, w);
                    total++; if (sc !== int'(lat) + 2) begin bad++; $display("[TB] FAIL rand_miss_stall: addr %h got %0d want %0d", a, sc, lat + 2); end
                    total++; if (ra !== (a & ~32'h3)) begin bad++; $display("[TB] FAIL rand_req_addr: got %h want %h", ra, a & ~32'h3); end
                    total++; if (rh !== 1'b1) begin bad++; $display("[TB] FAIL rand_req_held: addr %h got %b want 1", a, rh); end
                    total++; if (rq !== 1'b0) begin bad++; $display("[TB] FAIL rand_req_dropped: addr %h got %b want 0", a, rq); end
                    total++; if (sa !== 1'b0) begin bad++; $display("[TB] FAIL rand_stall_after: addr %h got %b want 0", a, sa); end
                    total++; if (da !== (ack_flush ? 32'h0 : w)) begin bad++; $display("[TB] FAIL rand_data_after: addr %h got %h want %h", a, da, ack_flush ? 32'h0 : w); end
                end
            end else if (op <= 8) begin
                // Idle cycle with ce low; a stray ack here must be ignored.
                ce = 1'b0; addr = a;
                mem_ack = $urandom_range(0, 1); mem_data = $urandom();
                @(negedge clock);
                total++; if (data_out !== 32'h0) begin bad++; $display("[TB] FAIL rand_idle_data: got %h want %h", data_out, 32'h0); end
                total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rand_idle_stall: got %b want 0", stall); end
                step();
                mem_ack = 1'b0;
                @(negedge clock);
                total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rand_idle_req: got %b want 0", mem_req); end
            end else begin
                ce = 1'b0; flush = 1'b1;
                step();
                flush = 1'b0;
                model_flush();
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_reset_mid_refill();
        test_ce_low();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
